// File: rtl/fir_stream_pkg.sv
// Shared widths, clog2 and round/saturate helper
// for the streaming FIR filter.
package fir_stream_pkg;

   localparam int MAXW = 128;

   typedef struct packed {
      logic               sat;
      logic signed [MAXW-1:0] val;
   } rs_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   function automatic int prod_w(input int dw, input int cw);
      return dw + cw;
   endfunction

   function automatic int acc_w(input int dw, input int cw,
                                input int taps);
      return prod_w(dw, cw) + clog2(taps);
   endfunction

   // raw holds acc_w significant bits, zero-padded above
   function automatic rs_t round_sat(input logic [MAXW-1:0] raw,
                                     input int acc_w,
                                     input int shift,
                                     input int out_w);
      logic signed [MAXW-1:0] one;
      logic signed [MAXW-1:0] r;
      logic signed [MAXW-1:0] hi;
      logic signed [MAXW-1:0] lo;
      rs_t o;
      one = '0;
      one[0] = 1'b1;
      r = signed'(raw);
      r = r <<< (MAXW - acc_w);
      r = r >>> (MAXW - acc_w);
      if (shift > 0) begin
         r = r + (one <<< (shift - 1));
         r = r >>> shift;
      end
      hi = (one <<< (out_w - 1)) - one;
      lo = -(one <<< (out_w - 1));
      o.sat = 1'b0;
      o.val = r;
      if (r > hi) begin
         o.sat = 1'b1;
         o.val = hi;
      end else if (r < lo) begin
         o.sat = 1'b1;
         o.val = lo;
      end
      return o;
   endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Combinational accumulator to output-width converter
// with half-up rounding and saturation.
module fir_round_sat
   import fir_stream_pkg::*;
#(
   parameter int ACC_W = 35,
   parameter int SHIFT = 0,
   parameter int OUT_W = 32
) (
   input  logic signed [ACC_W-1:0] acc,
   output logic signed [OUT_W-1:0] y,
   output logic                    sat
);

   rs_t  rs;
   logic unused_hi;

   always_comb begin
      rs = round_sat(MAXW'($unsigned(acc)), ACC_W, SHIFT, OUT_W);
   end

   assign y         = rs.val[OUT_W-1:0];
   assign sat       = rs.sat;
   assign unused_hi = ^rs.val[MAXW-1:OUT_W];

endmodule

// File: rtl/fir_stream_filter.sv
// Pipelined streaming FIR: delay line, coefficient file,
// product stage and rounded/saturated output stage.
module fir_stream_filter
   import fir_stream_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int COEF_W = 16,
   parameter int TAPS   = 8,
   parameter int OUT_W  = 32,
   parameter int SHIFT  = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     coef_we,
   input  logic [clog2(TAPS)-1:0]   coef_addr,
   input  logic signed [COEF_W-1:0] coef_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] data_in,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [OUT_W-1:0]  data_out,
   output logic                     sat_flag
);

   localparam int PW = prod_w(DATA_W, COEF_W);
   localparam int AW = acc_w(DATA_W, COEF_W, TAPS);

   logic signed [DATA_W-1:0] x [TAPS];
   logic signed [COEF_W-1:0] c [TAPS];
   logic signed [PW-1:0]     p [TAPS];
   logic                     v0;
   logic                     v1;
   logic                     stall;
   logic                     accept;
   logic                     sat;
   logic signed [AW-1:0]     acc;
   logic signed [OUT_W-1:0]  y;

   assign stall    = out_valid & ~out_ready;
   assign in_ready = ~stall & ~clr;
   assign accept   = in_valid & in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < TAPS; k++) c[k] <= '0;
      end else if (coef_we && int'(coef_addr) < TAPS) begin
         c[coef_addr] <= coef_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < TAPS; k++) begin
            x[k] <= '0;
            p[k] <= '0;
         end
         v0 <= 1'b0;
         v1 <= 1'b0;
      end else if (clr) begin
         for (int k = 0; k < TAPS; k++) x[k] <= '0;
         v0 <= 1'b0;
         v1 <= 1'b0;
      end else if (!stall) begin
         v0 <= accept;
         if (accept) begin
            x[0] <= data_in;
            for (int k = 1; k < TAPS; k++) x[k] <= x[k-1];
         end
         v1 <= v0;
         for (int k = 0; k < TAPS; k++) begin
            p[k] <= PW'(x[k]) * PW'(c[k]);
         end
      end
   end

   // Sum width has clog2(TAPS) guard bits, so it never wraps
   always_comb begin
      acc = '0;
      for (int k = 0; k < TAPS; k++) acc = acc + AW'(p[k]);
   end

   fir_round_sat #(
      .ACC_W (AW),
      .SHIFT (SHIFT),
      .OUT_W (OUT_W)
   ) u_rs (
      .acc (acc),
      .y   (y),
      .sat (sat)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_out  <= '0;
         out_valid <= 1'b0;
         sat_flag  <= 1'b0;
      end else if (clr) begin
         out_valid <= 1'b0;
         sat_flag  <= 1'b0;
      end else if (!stall) begin
         out_valid <= v1;
         if (v1) begin
            data_out <= y;
            sat_flag <= sat_flag | sat;
         end
      end
   end

endmodule

// File: doc/fir_stream_filter.md
# fir_stream_filter

Parametrised, pipelined streaming FIR filter: the next generation of the fixed 16-bit FIR in the signal-processing datapath. It generalises tap count and widths, adds run-time coefficient loading and valid/ready flow control on both sides, and applies rounding and saturation to a configurable output width. It sits between the sample source and downstream consumers that may stall.

## Interface
- DATA_W, 16: signed input sample width.
- COEF_W, 16: signed coefficient width.
- TAPS, 8: number of taps, ≥2.
- OUT_W, 32: signed output width.
- SHIFT, 0: arithmetic right shift applied to the accumulator before saturation, 0..ACC_W-1.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous flush.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  clog2(TAPS)  tap index; writes with index ≥TAPS are ignored.
- coef_data  in  COEF_W  signed coefficient.
- in_valid  in  1  input sample valid.
- in_ready  out  1  filter accepts a sample.
- data_in  in  DATA_W  signed sample.
- out_valid  out  1  data_out valid.
- out_ready  in  1  consumer accepts the output.
- data_out  out  OUT_W  signed filtered sample.
- sat_flag  out  1  sticky saturation indicator.

## Operation
- Reset (async): delay line x[0..TAPS-1], coefficients c[0..TAPS-1], products, all valid bits, data_out, out_valid and sat_flag go to 0. in_ready is 1 after reset.
- Arithmetic:
  - PROD_W = DATA_W+COEF_W.
  - ACC_W = PROD_W+clog2(TAPS), so the sum never wraps.
  - y = sum over k of x[k]*c[k], where x[0] is the newest sample.
  - Rounding: if SHIFT>0, add 2^(SHIFT-1) and then shift arithmetically right by SHIFT (round half up).
  - Saturation: clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. Any clamp sets sat_flag.
- Stall:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall & ~clr.
  - Accept = in_valid & in_ready.
- Pipeline. All stages advance only when ~stall; bubbles propagate as cleared valid bits.
  - S0: on accept, the delay line shifts (x[k] ← x[k-1], x[0] ← data_in) and v0 ← 1. Otherwise v0 ← 0 and the delay line holds.
  - S1: p[k] ← x[k]*c[k], v1 ← v0.
  - S2: sum, round and saturate into data_out; out_valid ← v1.
  - A handshake (out_valid & out_ready) with v1=0 clears out_valid.
- Coefficient write: c[coef_addr] ← coef_data on an edge with coef_we=1.
  - Allowed at any time, including during a stall.
  - An S1 computation on the same edge uses the old value.
- clr:
  - Zeroes the delay line, v0, v1, out_valid and sat_flag.
  - Coefficients and data_out are retained.
  - Overrides accept and stall in that cycle.
- rst mid-stream: all in-flight samples are discarded and coefficients are lost; they must be reloaded.

## Timing
- Latency: a sample accepted at edge E appears with out_valid=1 after edge E+2, provided no stall occurs.
- Throughput: one sample per cycle while out_ready=1.
- Backpressure:
  - in_ready falls combinationally in the same cycle out_valid=1 and out_ready=0.
  - data_out holds stable while stalled.
  - No sample is lost or duplicated.
- in_valid=0 cycles produce matching gaps in out_valid and do not shift the delay line.
- sat_flag rises on the edge where the saturated value is registered into data_out. It is cleared only by rst or clr.

## Structure
- Package fir_stream_pkg holds:
  - PROD_W and ACC_W derivation functions.
  - The clog2 helper.
  - A round/saturate function parameterised by ACC_W, SHIFT and OUT_W.
- Sub-module fir_round_sat: a combinational accumulator-to-OUT_W converter that outputs the clamped value and a sat bit. It is instantiated once in S2.
- The top level contains the delay line, coefficient register file, product registers, valid pipeline and handshake logic.

## Test plan
- Impulse response:
  - Setup: TAPS=8, c=1..8, SHIFT=0; drive data_in=1000, then zeros, with in_valid and out_ready high.
  - Expected: outputs 1000, 2000, …, 8000, then 0; the first output arrives 2 cycles after accept.
- Moving sum:
  - Setup: c[0..3]=1, c[4..7]=0; inputs 1000, -1000, 500, -500, then zeros.
  - Expected: outputs 1000, 0, 500, 0, -1000, 0, -500, 0.
- Saturation:
  - Setup: OUT_W=16, all c=32767, inputs of 32767.
  - Expected: data_out=32767 and sat_flag=1; sat_flag stays set until clr, then reads 0.
- Backpressure:
  - Setup: out_ready=0 for 5 cycles mid-stream.
  - Expected: in_ready=0 and data_out stable while stalled; after release the output sequence matches the no-stall golden model exactly.
- Coefficient write on the same edge as an S1 computation:
  - Setup: write c[0]: 1→2 on the edge where S1 computes.
  - Expected: that product uses 1; the next accepted sample uses 2.
- Reset mid-stream:
  - Setup: assert rst asynchronously between edges.
  - Expected: out_valid=0, data_out=0 and sat_flag=0 immediately; after reload, the impulse test passes again.
